// File: rtl/game_collision_detector_if.sv
// Drawing-request inputs and per-frame collision results between the object mux side
// (master) and game_collision_detector (slave).
interface game_collision_detector_if #(
    parameter int unsigned NUMBERS = 3,
    parameter int unsigned ROPES   = 6
);
    localparam int unsigned RopeIdxW = (ROPES > 1) ? $clog2(ROPES) : 1;
    localparam int unsigned NumIdxW  = (NUMBERS > 1) ? $clog2(NUMBERS) : 1;

    logic                startOfFrame;
    logic                monkeyDR;
    logic [ROPES-1:0]    ropesDR;
    logic [NUMBERS-1:0]  numbersDR;
    logic [1:0]          operandDR;
    logic                blocksDR;
    logic                waterDR;
    logic                ceilingDR;

    logic                hitRope;
    logic [RopeIdxW-1:0] ropeIdx;
    logic                hitNumber;
    logic [NumIdxW-1:0]  numberIdx;
    logic [1:0]          hitOperand;
    logic                hitBlock;
    logic                hitWater;
    logic                hitCeiling;
    logic                collisionPulse;

    modport master (
        output startOfFrame, monkeyDR, ropesDR, numbersDR, operandDR, blocksDR, waterDR,
               ceilingDR,
        input  hitRope, ropeIdx, hitNumber, numberIdx, hitOperand, hitBlock, hitWater,
               hitCeiling, collisionPulse
    );

    modport slave (
        input  startOfFrame, monkeyDR, ropesDR, numbersDR, operandDR, blocksDR, waterDR,
               ceilingDR,
        output hitRope, ropeIdx, hitNumber, numberIdx, hitOperand, hitBlock, hitWater,
               hitCeiling, collisionPulse
    );
endinterface

// File: rtl/game_collision_detector.sv
// Accumulates monkey-vs-object overlaps over a frame and publishes them at startOfFrame.
// Optional water-hit holdoff is enabled by defining COLLISION_HOLDOFF_EN.
module game_collision_detector #(
    parameter int unsigned NUMBERS        = 3,
    parameter int unsigned ROPES          = 6,
    parameter int unsigned HOLDOFF_FRAMES = 60
) (
    input  logic                      clk,
    input  logic                      resetN,
    game_collision_detector_if.slave  bus_io
);
    localparam int unsigned RopeIdxW = (ROPES > 1) ? $clog2(ROPES) : 1;
    localparam int unsigned NumIdxW  = (NUMBERS > 1) ? $clog2(NUMBERS) : 1;

    typedef enum logic {StAccum, StPublish} state_e;
    state_e state_q, state_d;

    logic [ROPES-1:0]    hit_r, acc_r_q, acc_r_d;
    logic [NUMBERS-1:0]  hit_n, acc_n_q, acc_n_d;
    logic [1:0]          hit_o, acc_o_q, acc_o_d;
    logic                hit_b, acc_b_q, acc_b_d;
    logic                hit_w, acc_w_q, acc_w_d;
    logic                hit_c, acc_c_q, acc_c_d;

    logic                pub_rope_q, pub_rope_d;
    logic [RopeIdxW-1:0] pub_ridx_q, pub_ridx_d, ridx_enc;
    logic                pub_num_q, pub_num_d;
    logic [NumIdxW-1:0]  pub_nidx_q, pub_nidx_d, nidx_enc;
    logic [1:0]          pub_op_q, pub_op_d;
    logic                pub_blk_q, pub_blk_d;
    logic                pub_wat_q, pub_wat_d;
    logic                pub_ceil_q, pub_ceil_d;
    logic                hold_active;

`ifdef COLLISION_HOLDOFF_EN
    localparam int unsigned HoldW = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;
    logic [HoldW-1:0] hold_q, hold_d;

    // A water hit seen during holdoff is itself suppressed, so it cannot reload.
    always_comb begin
        hold_d = hold_q;
        if (bus_io.startOfFrame) begin
            if (hold_q != '0) begin
                hold_d = hold_q - 1'b1;
            end else if (acc_w_q) begin
                hold_d = HoldW'(HOLDOFF_FRAMES);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign hold_active = (hold_q != '0);
`else
    if (HOLDOFF_FRAMES > 0) begin : g_holdoff_ignored
    end
    assign hold_active = 1'b0;
`endif

    always_comb begin
        hit_r = {ROPES{bus_io.monkeyDR}} & bus_io.ropesDR;
        hit_n = {NUMBERS{bus_io.monkeyDR}} & bus_io.numbersDR;
        hit_o = {2{bus_io.monkeyDR}} & bus_io.operandDR;
        hit_b = bus_io.monkeyDR & bus_io.blocksDR;
        hit_w = bus_io.monkeyDR & bus_io.waterDR;
        hit_c = bus_io.monkeyDR & bus_io.ceilingDR;

        // Lowest set index wins: scan downward so the last assignment is the lowest.
        ridx_enc = '0;
        for (int i = int'(ROPES) - 1; i >= 0; i--) begin
            if (acc_r_q[i]) ridx_enc = RopeIdxW'(i);
        end
        nidx_enc = '0;
        for (int i = int'(NUMBERS) - 1; i >= 0; i--) begin
            if (acc_n_q[i]) nidx_enc = NumIdxW'(i);
        end
    end

    always_comb begin
        state_d    = bus_io.startOfFrame ? StPublish : StAccum;
        acc_r_d    = acc_r_q | hit_r;
        acc_n_d    = acc_n_q | hit_n;
        acc_o_d    = acc_o_q | hit_o;
        acc_b_d    = acc_b_q | hit_b;
        acc_w_d    = acc_w_q | hit_w;
        acc_c_d    = acc_c_q | hit_c;
        pub_rope_d = pub_rope_q;
        pub_ridx_d = pub_ridx_q;
        pub_num_d  = pub_num_q;
        pub_nidx_d = pub_nidx_q;
        pub_op_d   = pub_op_q;
        pub_blk_d  = pub_blk_q;
        pub_wat_d  = pub_wat_q;
        pub_ceil_d = pub_ceil_q;

        if (bus_io.startOfFrame) begin
            // Hits on the frame-start cycle open the new frame.
            acc_r_d    = hit_r;
            acc_n_d    = hit_n;
            acc_o_d    = hit_o;
            acc_b_d    = hit_b;
            acc_w_d    = hit_w;
            acc_c_d    = hit_c;
            pub_rope_d = !hold_active && (|acc_r_q);
            pub_ridx_d = hold_active ? '0 : ridx_enc;
            pub_num_d  = !hold_active && (|acc_n_q);
            pub_nidx_d = hold_active ? '0 : nidx_enc;
            pub_op_d   = hold_active ? 2'b00 : acc_o_q;
            pub_blk_d  = !hold_active && acc_b_q;
            pub_wat_d  = !hold_active && acc_w_q;
            pub_ceil_d = !hold_active && acc_c_q;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= StAccum;
            acc_r_q    <= '0;
            acc_n_q    <= '0;
            acc_o_q    <= '0;
            acc_b_q    <= 1'b0;
            acc_w_q    <= 1'b0;
            acc_c_q    <= 1'b0;
            pub_rope_q <= 1'b0;
            pub_ridx_q <= '0;
            pub_num_q  <= 1'b0;
            pub_nidx_q <= '0;
            pub_op_q   <= '0;
            pub_blk_q  <= 1'b0;
            pub_wat_q  <= 1'b0;
            pub_ceil_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_r_q    <= acc_r_d;
            acc_n_q    <= acc_n_d;
            acc_o_q    <= acc_o_d;
            acc_b_q    <= acc_b_d;
            acc_w_q    <= acc_w_d;
            acc_c_q    <= acc_c_d;
            pub_rope_q <= pub_rope_d;
            pub_ridx_q <= pub_ridx_d;
            pub_num_q  <= pub_num_d;
            pub_nidx_q <= pub_nidx_d;
            pub_op_q   <= pub_op_d;
            pub_blk_q  <= pub_blk_d;
            pub_wat_q  <= pub_wat_d;
            pub_ceil_q <= pub_ceil_d;
        end
    end

    assign bus_io.hitRope        = pub_rope_q;
    assign bus_io.ropeIdx        = pub_ridx_q;
    assign bus_io.hitNumber      = pub_num_q;
    assign bus_io.numberIdx      = pub_nidx_q;
    assign bus_io.hitOperand     = pub_op_q;
    assign bus_io.hitBlock       = pub_blk_q;
    assign bus_io.hitWater       = pub_wat_q;
    assign bus_io.hitCeiling     = pub_ceil_q;
    assign bus_io.collisionPulse = (state_q == StPublish) &&
        (pub_rope_q || pub_num_q || (|pub_op_q) || pub_blk_q || pub_wat_q || pub_ceil_q);
endmodule
